// File: rtl/clock_display_scan.sv
// rtl/clock_display_scan.sv - six-digit multiplexed 7-segment scanner with frame snapshot,
// brightness PWM, blinking colon, leading-zero blanking and invalid-BCD dash.
module clock_display_scan #(
   parameter int SCAN_DIV   = 8333,
   parameter int BLINK_DIV  = 25_000_000,
   parameter int ACTIVE_LOW = 1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] s1,
   input  logic [3:0] s2,
   input  logic [3:0] m1,
   input  logic [3:0] m2,
   input  logic [3:0] h1,
   input  logic [3:0] h2,
   input  logic [2:0] bright,
   input  logic       blink,
   input  logic       lzb,
   output logic [5:0] an,
   output logic [6:0] seg,
   output logic       dp
);
   localparam int CW = $clog2(SCAN_DIV);
   localparam int LW = CW + 4;
   localparam int BW = $clog2(BLINK_DIV + 1);
   localparam logic [LW-1:0] SCAN_L = LW'(SCAN_DIV);

   logic [CW-1:0]     cnt_q, cnt_d;
   logic [2:0]        idx_q, idx_d;
   logic [5:0][3:0]   snap_q, snap_d;
   logic              phase_q, phase_d;
   logic [BW-1:0]     blink_q, blink_d;
   logic [5:0]        an_q, an_d;
   logic [6:0]        seg_q, seg_d;
   logic              dp_q, dp_d;

   logic              last_slot;
   logic              lit;
   logic              blank;
   logic [LW-1:0]     on_len;
   logic [3:0]        digit;

   function automatic logic [6:0] seg7(input logic [3:0] v);
      case (v)
         4'd0:    seg7 = 7'h3F;
         4'd1:    seg7 = 7'h06;
         4'd2:    seg7 = 7'h5B;
         4'd3:    seg7 = 7'h4F;
         4'd4:    seg7 = 7'h66;
         4'd5:    seg7 = 7'h6D;
         4'd6:    seg7 = 7'h7D;
         4'd7:    seg7 = 7'h07;
         4'd8:    seg7 = 7'h7F;
         4'd9:    seg7 = 7'h6F;
         default: seg7 = 7'h40;
      endcase
   endfunction

   always_comb begin
      last_slot = (cnt_q == CW'(SCAN_DIV - 1));
      cnt_d     = last_slot ? '0 : cnt_q + 1'b1;
      idx_d     = idx_q;
      if (last_slot) idx_d = (idx_q == 3'd5) ? 3'd0 : idx_q + 3'd1;

      // Latch the whole frame at once so a digit never tears mid-scan.
      snap_d = snap_q;
      if (last_slot && idx_q == 3'd5) snap_d = {h2, h1, m2, m1, s2, s1};

      blink_d = blink_q + 1'b1;
      phase_d = phase_q;
      if (blink_q == BW'(BLINK_DIV - 1)) begin
         blink_d = '0;
         phase_d = ~phase_q;
      end

      case (idx_q)
         3'd0:    digit = snap_q[0];
         3'd1:    digit = snap_q[1];
         3'd2:    digit = snap_q[2];
         3'd3:    digit = snap_q[3];
         3'd4:    digit = snap_q[4];
         default: digit = snap_q[5];
      endcase

      // cnt = 0 stays dark as a ghosting guard between digits.
      on_len = ((LW'(bright) + LW'(1)) * SCAN_L) >> 3;
      lit    = (cnt_q != '0) && (LW'(cnt_q) <= on_len);
      blank  = lzb && (idx_q == 3'd5) && (snap_q[5] == 4'd0);

      an_d  = 6'd0;
      seg_d = 7'h00;
      if (lit && !blank) begin
         an_d  = 6'd1 << idx_q;
         seg_d = seg7(digit);
      end
      dp_d = lit && (idx_q == 3'd2 || idx_q == 3'd4) && (!blink || phase_q);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q   <= '0;
         idx_q   <= '0;
         snap_q  <= '0;
         phase_q <= 1'b0;
         blink_q <= '0;
         an_q    <= '0;
         seg_q   <= '0;
         dp_q    <= 1'b0;
      end else begin
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         snap_q  <= snap_d;
         phase_q <= phase_d;
         blink_q <= blink_d;
         an_q    <= an_d;
         seg_q   <= seg_d;
         dp_q    <= dp_d;
      end
   end

   assign an  = (ACTIVE_LOW != 0) ? ~an_q  : an_q;
   assign seg = (ACTIVE_LOW != 0) ? ~seg_q : seg_q;
   assign dp  = (ACTIVE_LOW != 0) ? ~dp_q  : dp_q;
endmodule

// File: tb/tb_clock_display_scan.sv
// tb/tb_clock_display_scan.sv - checks active-high and active-low scanners against a
// cycle-indexed arithmetic model of the display timing.
module tb_clock_display_scan;
   localparam int S  = 8;
   localparam int B  = 20;
   localparam int FR = 6 * S;

   logic       clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst;
   logic [3:0] dig [6];
   logic [2:0] bright;
   logic       blink, lzb;
   logic [5:0] an0, an1;
   logic [6:0] seg0, seg1;
   logic       dp0, dp1;

   clock_display_scan #(.SCAN_DIV(S), .BLINK_DIV(B), .ACTIVE_LOW(0)) dut0 (
      .clk(clk), .rst(rst),
      .s1(dig[0]), .s2(dig[1]), .m1(dig[2]), .m2(dig[3]), .h1(dig[4]), .h2(dig[5]),
      .bright(bright), .blink(blink), .lzb(lzb),
      .an(an0), .seg(seg0), .dp(dp0)
   );

   clock_display_scan #(.SCAN_DIV(S), .BLINK_DIV(B), .ACTIVE_LOW(1)) dut1 (
      .clk(clk), .rst(rst),
      .s1(dig[0]), .s2(dig[1]), .m1(dig[2]), .m2(dig[3]), .h1(dig[4]), .h2(dig[5]),
      .bright(bright), .blink(blink), .lzb(lzb),
      .an(an1), .seg(seg1), .dp(dp1)
   );

   int         checks = 0;
   int         errors = 0;
   int         t_m = 0;
   logic [3:0] msnap [6];
   logic [6:0] seg_tab [16];
   logic [5:0] e_an;
   logic [6:0] e_seg;
   logic       e_dp;

   task automatic chk(input string tag, input logic [6:0] got, input logic [6:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s t=%0d observed %h expected %h", tag, t_m, got, exp);
      end
   endtask

   // t_m = clocks since reset; position, frame and colon phase follow by division.
   task automatic tick();
      int c, i, onl;
      bit lit;
      e_an = '0; e_seg = '0; e_dp = 1'b0;
      if (rst) begin
         t_m = 0;
         for (int k = 0; k < 6; k++) msnap[k] = 4'd0;
      end else begin
         c   = t_m % S;
         i   = (t_m / S) % 6;
         onl = ((int'(bright) + 1) * S) / 8;
         lit = (c >= 1) && (c <= onl);
         if (lit && !(lzb && i == 5 && msnap[5] == 4'd0)) begin
            e_an[i] = 1'b1;
            e_seg   = seg_tab[msnap[i]];
         end
         if (lit && (i == 2 || i == 4) && (!blink || ((t_m / B) % 2 == 1))) e_dp = 1'b1;
         if (t_m % FR == FR - 1)
            for (int k = 0; k < 6; k++) msnap[k] = dig[k];
         t_m++;
      end
      @(posedge clk);
      @(negedge clk);
      chk("an_hi",  {1'b0, an0},  {1'b0, e_an});
      chk("seg_hi", seg0,         e_seg);
      chk("dp_hi",  {6'd0, dp0},  {6'd0, e_dp});
      chk("an_lo",  {1'b0, an1},  {1'b0, ~e_an});
      chk("seg_lo", seg1,         ~e_seg);
      chk("dp_lo",  {6'd0, dp1},  {6'd0, ~e_dp});
   endtask

   task automatic run(input int n);
      for (int k = 0; k < n; k++) tick();
   endtask

   task automatic run_to(input int pos);
      for (int k = 0; k < FR && (t_m % FR) != pos; k++) tick();
   endtask

   initial begin
      seg_tab[0] = 7'h3F; seg_tab[1] = 7'h06; seg_tab[2] = 7'h5B; seg_tab[3] = 7'h4F;
      seg_tab[4] = 7'h66; seg_tab[5] = 7'h6D; seg_tab[6] = 7'h7D; seg_tab[7] = 7'h07;
      seg_tab[8] = 7'h7F; seg_tab[9] = 7'h6F;
      for (int k = 10; k < 16; k++) seg_tab[k] = 7'h40;
      for (int k = 0; k < 6; k++) begin dig[k] = 4'd0; msnap[k] = 4'd0; end
      rst = 1'b1; bright = 3'd7; blink = 1'b0; lzb = 1'b0;
      @(negedge clk);

      run(2);
      rst = 1'b0;
      run(FR);

      dig[5] = 4'd1; dig[4] = 4'd2; dig[3] = 4'd3;
      dig[2] = 4'd4; dig[1] = 4'd5; dig[0] = 4'd6;
      run(2 * FR);

      run_to(3 * S);
      dig[0] = 4'd9;
      run(2 * FR);

      bright = 3'd0; run(FR);
      bright = 3'd3; run(FR);
      bright = 3'd7;

      dig[5] = 4'd0; lzb = 1'b1; run(2 * FR);
      lzb = 1'b0; run(FR);
      dig[1] = 4'd12; run(2 * FR);

      blink = 1'b1; run(5 * FR);
      blink = 1'b0; run(FR);

      run_to(3 * S + 2);
      rst = 1'b1; run(1);
      rst = 1'b0; run(2 * FR);

      for (int n = 0; n < 1200; n++) begin
         if ($urandom_range(0, 7) == 0) dig[$urandom_range(0, 5)] = 4'($urandom_range(0, 15));
         if ($urandom_range(0, 31) == 0) bright = 3'($urandom_range(0, 7));
         if ($urandom_range(0, 63) == 0) blink = 1'($urandom_range(0, 1));
         if ($urandom_range(0, 63) == 0) lzb = 1'($urandom_range(0, 1));
         if ($urandom_range(0, 15) == 0) dig[5] = 4'd0;
         tick();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
